set_assoc_cache: RTL

- Parametrised N-way set-associative, write-back, write-allocate data cache.
- Sits between the pipeline memory stage (CPU side) and the block RAM (memory side).
- Fully clocked FSM with explicit valid/ready CPU handshake and req/ack memory handshake.
- Adds true-LRU replacement, dirty-bit tracking, alignment error reporting and hit/miss counters.

---
 rtl/set_assoc_cache_if.sv | 37 +++
 rtl/set_assoc_cache.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache_if.sv
// CPU request/response and block-memory handshake bundle for set_assoc_cache.
// The cache takes the slave side; the CPU plus block RAM environment takes master.
interface set_assoc_cache_if #(
    parameter int ADDR_W  = 16,
    parameter int WORD_W  = 16,
    parameter int BLOCK_W = 32,
    parameter int CNT_W   = 16
);
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [ADDR_W-1:0]  req_addr;
    logic [WORD_W-1:0]  req_wdata;
    logic               resp_valid;
    logic [WORD_W-1:0]  resp_rdata;
    logic               resp_err;
    logic               mem_req;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [BLOCK_W-1:0] mem_wdata;
    logic               mem_ack;
    logic [BLOCK_W-1:0] mem_rdata;
    logic [CNT_W-1:0]   hit_cnt;
    logic [CNT_W-1:0]   miss_cnt;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back / write-allocate data cache with true-LRU
// replacement, sitting between the CPU memory stage and a block RAM.
module set_assoc_cache #(
    parameter int NUM_SETS = 8,
    parameter int NUM_WAYS = 4,
    parameter int ADDR_W   = 16,
    parameter int WORD_W   = 16,
    parameter int BLOCK_W  = 2 * WORD_W,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    set_assoc_cache_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        REFILL    = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    state_t              state_r, state_nx_s;
    logic [ADDR_W-1:0]   req_addr_r;
    logic                req_we_r;
    logic [WORD_W-1:0]   req_wdata_r;
    logic [WAY_W-1:0]    victim_r;
    logic [NUM_WAYS-1:0] valid_r [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_r [NUM_SETS];
    logic [WAY_W-1:0]    age_r   [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_r   [NUM_SETS][NUM_WAYS];
    logic [BLOCK_W-1:0]  data_r  [NUM_SETS][NUM_WAYS];
    logic [CNT_W-1:0]    hit_cnt_r, miss_cnt_r;
    logic                req_ready_r, resp_valid_r, resp_err_r;
    logic [WORD_W-1:0]   resp_rdata_r;
    logic                mem_req_r, mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [BLOCK_W-1:0]  mem_wdata_r;

    logic [IDX_W-1:0]    idx_s;
    logic [TAG_W-1:0]    tag_s;
    logic                misalign_s, word_sel_s;
    logic                hit_s, victim_dirty_s;
    logic [WAY_W-1:0]    hit_way_s, victim_s, max_age_s, acc_way_s, acc_age_s;
    logic                do_hit_s, do_miss_s, do_fill_s;
    logic [BLOCK_W-1:0]  base_blk_s, new_blk_s;
    logic [WORD_W-1:0]   rd_word_s;

    function automatic logic [BLOCK_W-1:0] merge_word(input logic [BLOCK_W-1:0] blk,
                                                      input logic sel,
                                                      input logic [WORD_W-1:0] wd);
        logic [BLOCK_W-1:0] res;
        res = blk;
        if (sel) res[BLOCK_W-1 -: WORD_W] = wd;
        else     res[WORD_W-1:0]          = wd;
        return res;
    endfunction

    assign idx_s      = req_addr_r[2 +: IDX_W];
    assign tag_s      = req_addr_r[ADDR_W-1 -: TAG_W];
    assign misalign_s = req_addr_r[0];
    assign word_sel_s = req_addr_r[1];

    // Tag compare and victim choice: lowest invalid way, otherwise the oldest way.
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = '0;
        victim_s  = '0;
        max_age_s = age_r[idx_s][0];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_s     = hit_s;
            end
            if (age_r[idx_s][w] > max_age_s) begin
                max_age_s = age_r[idx_s][w];
                victim_s  = WAY_W'(w);
            end else begin
                max_age_s = max_age_s;
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_r[idx_s][w]) victim_s = WAY_W'(w);
            else                    victim_s = victim_s;
        end
        victim_dirty_s = valid_r[idx_s][victim_s] && dirty_r[idx_s][victim_s];
    end

    assign do_hit_s   = (state_r == LOOKUP) && !misalign_s && hit_s;
    assign do_miss_s  = (state_r == LOOKUP) && !misalign_s && !hit_s;
    assign do_fill_s  = (state_r == REFILL) && mem_req_r && bus.mem_ack;
    assign acc_way_s  = (state_r == REFILL) ? victim_r : hit_way_s;
    assign acc_age_s  = age_r[idx_s][acc_way_s];
    assign base_blk_s = (state_r == REFILL) ? bus.mem_rdata : data_r[idx_s][hit_way_s];
    assign new_blk_s  = req_we_r ? merge_word(base_blk_s, word_sel_s, req_wdata_r) : base_blk_s;
    assign rd_word_s  = word_sel_s ? base_blk_s[BLOCK_W-1 -: WORD_W] : base_blk_s[WORD_W-1:0];

    // Next-state decode; a memory ack only counts while our request is up.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) state_nx_s = LOOKUP;
                else               state_nx_s = IDLE;
            end
            LOOKUP: begin
                if (misalign_s || hit_s) state_nx_s = RESPOND;
                else if (victim_dirty_s) state_nx_s = WRITEBACK;
                else                     state_nx_s = REFILL;
            end
            WRITEBACK: begin
                if (mem_req_r && bus.mem_ack) state_nx_s = REFILL;
                else                          state_nx_s = WRITEBACK;
            end
            REFILL: begin
                if (mem_req_r && bus.mem_ack) state_nx_s = RESPOND;
                else                          state_nx_s = REFILL;
            end
            RESPOND: state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State, request capture, line status, LRU ages, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            req_addr_r   <= '0;
            req_we_r     <= 1'b0;
            req_wdata_r  <= '0;
            victim_r     <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age_r[s][w] <= WAY_W'(w);
            end
            hit_cnt_r    <= '0;
            miss_cnt_r   <= '0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
        end else begin
            state_r <= state_nx_s;
            if (bus.req_valid && req_ready_r) begin
                req_addr_r  <= bus.req_addr;
                req_we_r    <= bus.req_we;
                req_wdata_r <= bus.req_wdata;
            end
            if (state_r == LOOKUP) victim_r <= victim_s;
            if (do_fill_s) begin
                valid_r[idx_s][victim_r] <= 1'b1;
                dirty_r[idx_s][victim_r] <= req_we_r;
            end else if (do_hit_s && req_we_r) begin
                dirty_r[idx_s][hit_way_s] <= 1'b1;
            end
            if (do_hit_s || do_fill_s) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == acc_way_s)          age_r[idx_s][w] <= '0;
                    else if (age_r[idx_s][w] < acc_age_s) age_r[idx_s][w] <= age_r[idx_s][w] + WAY_W'(1);
                end
            end
            if (do_hit_s && (hit_cnt_r != {CNT_W{1'b1}}))   hit_cnt_r  <= hit_cnt_r + CNT_W'(1);
            if (do_miss_s && (miss_cnt_r != {CNT_W{1'b1}})) miss_cnt_r <= miss_cnt_r + CNT_W'(1);

            req_ready_r  <= (state_nx_s == IDLE);
            resp_valid_r <= (state_nx_s == RESPOND);
            resp_err_r   <= (state_r == LOOKUP) && misalign_s;
            if (do_hit_s || do_fill_s)               resp_rdata_r <= req_we_r ? '0 : rd_word_s;
            else if ((state_r == LOOKUP) && misalign_s) resp_rdata_r <= '0;

            // Dropping req for one cycle after each ack separates back-to-back transactions.
            mem_req_r <= ((state_nx_s == WRITEBACK) || (state_nx_s == REFILL)) && !(mem_req_r && bus.mem_ack);
            mem_we_r  <= (state_nx_s == WRITEBACK);
            if ((state_r == LOOKUP) && (state_nx_s == WRITEBACK)) begin
                mem_addr_r  <= {tag_r[idx_s][victim_s], idx_s, 2'b00};
                mem_wdata_r <= data_r[idx_s][victim_s];
            end else if ((state_r != REFILL) && (state_nx_s == REFILL)) begin
                mem_addr_r  <= {tag_s, idx_s, 2'b00};
            end
        end
    end

    // Tag/data array writes; contents are qualified by valid_r so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_fill_s) tag_r[idx_s][victim_r] <= tag_s;
        if (do_hit_s || do_fill_s) data_r[idx_s][acc_way_s] <= new_blk_s;
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.mem_req    = mem_req_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.hit_cnt    = hit_cnt_r;
    assign bus.miss_cnt   = miss_cnt_r;
endmodule
